uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte queue behind uart_rx: first-word fall-through, never stalls upstream.
// Optional macro UART_RX_FIFO_ERR_EN keeps frame errors per byte (adds out_frame_err).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_valid      byte strobe from the receiver
//   in_frame_err          stop-bit error for in_data
//   out_data/out_valid    head of queue (out_data = 0 when empty)
//   out_ready             consumer pops the head this cycle
//   count                 occupancy, 0..DEPTH
//   overflow              sticky drop flag, cleared by clr_overflow
//   drop_cnt              saturating count of dropped bytes
//   out_frame_err         (UART_RX_FIFO_ERR_EN only) error bit of head entry

module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_frame_err,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [7:0]             drop_cnt
`ifdef UART_RX_FIFO_ERR_EN
  ,
  output logic                   out_frame_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef UART_RX_FIFO_ERR_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [EW-1:0] head;
  logic [EW-1:0] entry;
  logic          accept;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

`ifdef UART_RX_FIFO_ERR_EN
  assign accept = in_valid;
  assign entry  = {in_frame_err, in_data};
`else
  // Errored bytes vanish without touching overflow state.
  assign accept = in_valid & ~in_frame_err;
  assign entry  = in_data;
`endif

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the slot at wr_ptr == rd_ptr.
  assign wr_en     = accept & (~full | pop);
  assign drop      = accept & full & ~pop;

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[7:0] : 8'h00;

`ifdef UART_RX_FIFO_ERR_EN
  assign out_frame_err = out_valid ? head[8] : 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16).
// Vector table for basic flow, hand sequences for full/overflow/wrap.

module tb_uart_rx_fifo;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_frame_err;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] drop_cnt;
`ifdef UART_RX_FIFO_ERR_EN
  logic       out_frame_err;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_frame_err (in_frame_err),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_cnt     (drop_cnt)
`ifdef UART_RX_FIFO_ERR_EN
    ,
    .out_frame_err(out_frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       fe;
    logic       rdy;
    logic       clr;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       eo;
    logic [7:0] edc;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    in_frame_err = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic rdy);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = rdy;
    step();
    idle();
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
    end
  endtask

  initial begin
    vt[0]  = '{H, H, L, L, L, 8'h77, L, 8'h00, 5'd0, L, 8'd0};
    vt[1]  = '{L, L, L, L, L, 8'h00, L, 8'h00, 5'd0, L, 8'd0};
    vt[2]  = '{L, H, L, L, L, 8'hA5, H, 8'hA5, 5'd1, L, 8'd0};
    vt[3]  = '{L, L, L, L, L, 8'h00, H, 8'hA5, 5'd1, L, 8'd0};
    vt[4]  = '{L, L, L, H, L, 8'h00, L, 8'h00, 5'd0, L, 8'd0};
    vt[5]  = '{L, L, L, H, L, 8'h00, L, 8'h00, 5'd0, L, 8'd0};
    vt[6]  = '{L, H, L, L, L, 8'h11, H, 8'h11, 5'd1, L, 8'd0};
    vt[7]  = '{L, H, L, H, L, 8'h22, H, 8'h22, 5'd1, L, 8'd0};
    vt[8]  = '{L, H, L, L, L, 8'h33, H, 8'h22, 5'd2, L, 8'd0};
    vt[9]  = '{L, L, L, H, L, 8'h00, H, 8'h33, 5'd1, L, 8'd0};
    vt[10] = '{L, L, L, H, L, 8'h00, L, 8'h00, 5'd0, L, 8'd0};
    vt[11] = '{H, H, L, L, L, 8'h99, L, 8'h00, 5'd0, L, 8'd0};

    idle();
    for (int i = 0; i < 12; i++) begin
      rst          = vt[i].rst;
      in_valid     = vt[i].iv;
      in_frame_err = vt[i].fe;
      out_ready    = vt[i].rdy;
      clr_overflow = vt[i].clr;
      in_data      = vt[i].din;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vt[i].ed));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].ec));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].eo));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vt[i].edc));
    end
    idle();

    // Fill, drop while full, drain in order.
    do_reset();
    fill16();
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd0);
    chk("fill_head", 32'(out_data), 32'h00);
    push(8'hFF, 1'b0);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_v%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain_d%0d", i), 32'(out_data), 32'(i));
      out_ready = 1'b1;
      step();
      idle();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Write while full with simultaneous pop.
    do_reset();
    fill16();
    push(8'h5A, 1'b1);
    chk("wp_count", 32'(count), 32'd16);
    chk("wp_ovf", 32'(overflow), 32'd0);
    chk("wp_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wp_d%0d", i), 32'(out_data),
          (i < 15) ? 32'(i + 1) : 32'h5A);
      out_ready = 1'b1;
      step();
      idle();
    end
    chk("wp_empty", 32'(out_valid), 32'd0);

    // Clear vs drop priority and drop_cnt saturation.
    do_reset();
    fill16();
    clr_overflow = 1'b1;
    push(8'hEE, 1'b0);
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    clr_overflow = 1'b1;
    step();
    idle();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(drop_cnt), 32'd1);
    chk("clr_count", 32'(count), 32'd16);
    for (int i = 0; i < 260; i++) begin
      push(8'hEE, 1'b0);
    end
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_head", 32'(out_data), 32'h00);

    // Pointer wrap, then reset mid-stream.
    do_reset();
    push(8'h40, 1'b0);
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h41 + i), 1'b1);
      chk($sformatf("wrap_d%0d", i), 32'(out_data), 32'(8'h41 + i));
      chk($sformatf("wrap_c%0d", i), 32'(count), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h60 + i), 1'b0);
    end
    chk("mid_count", 32'(count), 32'd5);
    chk("mid_head", 32'(out_data), 32'h54);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    idle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    // Frame error byte.
    do_reset();
    in_frame_err = 1'b1;
    push(8'h3C, 1'b0);
`ifdef UART_RX_FIFO_ERR_EN
    chk("fe_count", 32'(count), 32'd1);
    chk("fe_data", 32'(out_data), 32'h3C);
    chk("fe_flag", 32'(out_frame_err), 32'd1);
`else
    chk("fe_count", 32'(count), 32'd0);
    chk("fe_valid", 32'(out_valid), 32'd0);
    fill16();
    in_frame_err = 1'b1;
    push(8'h3C, 1'b0);
    chk("fe_full_ovf", 32'(overflow), 32'd0);
    chk("fe_full_drop", 32'(drop_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
